banco_registradores_multiporta: RTL and testbench



---
 rtl/banco_registradores_multiporta_if.sv | 28 ++
 rtl/banco_registradores_multiporta.sv | 89 ++++++++
 tb/tb_banco_registradores_multiporta.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/banco_registradores_multiporta_if.sv
// rtl/banco_registradores_multiporta_if.sv - register file bus: two read ports, one write port, bulk-clear handshake
interface banco_registradores_multiporta_if #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 32
);
  localparam int END_W = $clog2(PROFUNDIDADE);

  logic [END_W-1:0]   endereco_1;
  logic [END_W-1:0]   endereco_2;
  logic [END_W-1:0]   endereco_escrita;
  logic [LARGURA-1:0] dado_escrita;
  logic               controle_escrita;
  logic               limpar;
  logic [LARGURA-1:0] dado_1;
  logic [LARGURA-1:0] dado_2;
  logic               ocupado;
  logic               concluido;

  modport master (
    output endereco_1, endereco_2, endereco_escrita, dado_escrita, controle_escrita, limpar,
    input  dado_1, dado_2, ocupado, concluido
  );

  modport slave (
    input  endereco_1, endereco_2, endereco_escrita, dado_escrita, controle_escrita, limpar,
    output dado_1, dado_2, ocupado, concluido
  );
endinterface

// File: rtl/banco_registradores_multiporta.sv
// rtl/banco_registradores_multiporta.sv - parametrised 2R/1W register file with optional zero entry, bypass and sequenced clear
module banco_registradores_multiporta #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 32,
  parameter int ZERO_FIXO    = 1,
  parameter int BYPASS       = 1
) (
  input  logic clock,
  input  logic reset,
  banco_registradores_multiporta_if.slave bus
);
  localparam int END_W = $clog2(PROFUNDIDADE);
  localparam logic [END_W-1:0] ULTIMO = END_W'(PROFUNDIDADE - 1);

  typedef enum logic {OCIOSO, LIMPANDO} estado_t;

  estado_t            estado_q, estado_d;
  logic [END_W-1:0]   ponteiro_q, ponteiro_d;
  logic               concluido_q, concluido_d;
  logic [LARGURA-1:0] mem_q [PROFUNDIDADE];
  logic [LARGURA-1:0] mem_d [PROFUNDIDADE];
  logic               escreve;

  always_comb begin
    escreve = bus.controle_escrita && (estado_q == OCIOSO) &&
              !((ZERO_FIXO != 0) && (bus.endereco_escrita == '0));
    estado_d    = estado_q;
    ponteiro_d  = ponteiro_q;
    concluido_d = 1'b0;
    mem_d       = mem_q;
    case (estado_q)
      OCIOSO: begin
        if (escreve) mem_d[bus.endereco_escrita] = bus.dado_escrita;
        if (bus.limpar) begin
          estado_d   = LIMPANDO;
          ponteiro_d = '0;
        end
      end
      LIMPANDO: begin
        mem_d[ponteiro_q] = '0;
        // Explicit terminal compare; the pointer is reloaded rather than left to overflow.
        if (ponteiro_q == ULTIMO) begin
          estado_d    = OCIOSO;
          ponteiro_d  = '0;
          concluido_d = 1'b1;
        end else begin
          ponteiro_d = ponteiro_q + END_W'(1);
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      ponteiro_q  <= '0;
      concluido_q <= 1'b0;
      for (int i = 0; i < PROFUNDIDADE; i++) mem_q[i] <= '0;
    end else begin
      estado_q    <= estado_d;
      ponteiro_q  <= ponteiro_d;
      concluido_q <= concluido_d;
      mem_q       <= mem_d;
    end
  end

  // escreve already excludes the clear and the fixed-zero entry, so bypass inherits both.
  always_comb begin
    if ((ZERO_FIXO != 0) && (bus.endereco_1 == '0))
      bus.dado_1 = '0;
    else if ((BYPASS != 0) && escreve && (bus.endereco_1 == bus.endereco_escrita))
      bus.dado_1 = bus.dado_escrita;
    else
      bus.dado_1 = mem_q[bus.endereco_1];
  end

  always_comb begin
    if ((ZERO_FIXO != 0) && (bus.endereco_2 == '0))
      bus.dado_2 = '0;
    else if ((BYPASS != 0) && escreve && (bus.endereco_2 == bus.endereco_escrita))
      bus.dado_2 = bus.dado_escrita;
    else
      bus.dado_2 = mem_q[bus.endereco_2];
  end

  assign bus.ocupado   = (estado_q == LIMPANDO);
  assign bus.concluido = concluido_q;
endmodule

// File: tb/tb_banco_registradores_multiporta.sv
// tb/tb_banco_registradores_multiporta.sv - directed self-checking bench for banco_registradores_multiporta
module tb_banco_registradores_multiporta;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  banco_registradores_multiporta_if #(.LARGURA(32), .PROFUNDIDADE(32)) a ();
  banco_registradores_multiporta_if #(.LARGURA(32), .PROFUNDIDADE(32)) b ();
  banco_registradores_multiporta_if #(.LARGURA(16), .PROFUNDIDADE(8))  c ();

  banco_registradores_multiporta #(.LARGURA(32), .PROFUNDIDADE(32), .ZERO_FIXO(1), .BYPASS(1))
    dut_a (.clock(clock), .reset(reset), .bus(a));
  banco_registradores_multiporta #(.LARGURA(32), .PROFUNDIDADE(32), .ZERO_FIXO(1), .BYPASS(0))
    dut_b (.clock(clock), .reset(reset), .bus(b));
  banco_registradores_multiporta #(.LARGURA(16), .PROFUNDIDADE(8), .ZERO_FIXO(0), .BYPASS(1))
    dut_c (.clock(clock), .reset(reset), .bus(c));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clock);
    a.controle_escrita = 1'b1; a.endereco_escrita = addr; a.dado_escrita = data;
    @(negedge clock);
    a.controle_escrita = 1'b0;
  endtask

  task automatic wr_b(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clock);
    b.controle_escrita = 1'b1; b.endereco_escrita = addr; b.dado_escrita = data;
    @(negedge clock);
    b.controle_escrita = 1'b0;
  endtask

  task automatic wr_c(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clock);
    c.controle_escrita = 1'b1; c.endereco_escrita = addr; c.dado_escrita = data;
    @(negedge clock);
    c.controle_escrita = 1'b0;
  endtask

  // Pulses limpar on instance a and counts busy cycles / done pulses over 40 cycles.
  task automatic clear_a(output int oc, output int cc, output int cyc);
    @(negedge clock); a.limpar = 1'b1;
    @(negedge clock); a.limpar = 1'b0;
    oc = 0; cc = 0; cyc = 0;
    for (int n = 1; n <= 40; n++) begin
      #1;
      if (a.ocupado) oc++;
      if (a.concluido) begin cc++; cyc = n; end
      @(negedge clock);
    end
  endtask

  int oc, cc, cyc;

  initial begin
    a.endereco_1 = '0; a.endereco_2 = '0; a.endereco_escrita = '0; a.dado_escrita = '0;
    a.controle_escrita = 1'b0; a.limpar = 1'b0;
    b.endereco_1 = '0; b.endereco_2 = '0; b.endereco_escrita = '0; b.dado_escrita = '0;
    b.controle_escrita = 1'b0; b.limpar = 1'b0;
    c.endereco_1 = '0; c.endereco_2 = '0; c.endereco_escrita = '0; c.dado_escrita = '0;
    c.controle_escrita = 1'b0; c.limpar = 1'b0;
    #12;
    @(negedge clock); reset = 1'b0;

    #1;
    chk("reset_ocupado", {31'b0, a.ocupado}, 32'd0);
    chk("reset_concluido", {31'b0, a.concluido}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      a.endereco_1 = 5'(i); a.endereco_2 = 5'(31 - i);
      #1;
      chk($sformatf("reset_rd1_%0d", i), a.dado_1, 32'd0);
      chk($sformatf("reset_rd2_%0d", 31 - i), a.dado_2, 32'd0);
    end

    wr_a(5'd5, 32'hDEADBEEF);
    a.endereco_1 = 5'd5; a.endereco_2 = 5'd5;
    #1;
    chk("wr5_rd1", a.dado_1, 32'hDEADBEEF);
    chk("wr5_rd2", a.dado_2, 32'hDEADBEEF);

    @(negedge clock);
    a.controle_escrita = 1'b1; a.endereco_escrita = 5'd0; a.dado_escrita = 32'h1234; a.endereco_1 = 5'd0;
    #1;
    chk("zero_no_bypass", a.dado_1, 32'd0);
    @(negedge clock);
    a.controle_escrita = 1'b0;
    #1;
    chk("zero_after_write", a.dado_1, 32'd0);

    @(negedge clock);
    a.controle_escrita = 1'b1; a.endereco_escrita = 5'd7; a.dado_escrita = 32'hA5A5A5A5; a.endereco_1 = 5'd7;
    #1;
    chk("bypass_on", a.dado_1, 32'hA5A5A5A5);
    @(negedge clock);
    a.controle_escrita = 1'b0;

    wr_b(5'd7, 32'h11111111);
    b.controle_escrita = 1'b1; b.endereco_escrita = 5'd7; b.dado_escrita = 32'hA5A5A5A5; b.endereco_1 = 5'd7;
    #1;
    chk("bypass_off_old", b.dado_1, 32'h11111111);
    @(negedge clock);
    b.controle_escrita = 1'b0;
    #1;
    chk("bypass_off_new", b.dado_1, 32'hA5A5A5A5);

    for (int i = 1; i < 32; i++) wr_a(5'(i), 32'(i * 3));
    a.endereco_1 = 5'd31; a.endereco_2 = 5'd9;
    #1;
    chk("fill_31", a.dado_1, 32'd93);
    chk("fill_9", a.dado_2, 32'd27);

    // Main clear with mid-clear probes, a dropped write and an ignored re-request.
    @(negedge clock); a.limpar = 1'b1;
    @(negedge clock); a.limpar = 1'b0;
    oc = 0; cc = 0; cyc = 0;
    for (int n = 1; n <= 40; n++) begin
      #1;
      if (a.ocupado) oc++;
      if (a.concluido) begin cc++; cyc = n; end
      if (n == 11) begin
        a.endereco_1 = 5'd31; a.endereco_2 = 5'd3;
        #1;
        chk("mid_31_old", a.dado_1, 32'd93);
        chk("mid_3_cleared", a.dado_2, 32'd0);
      end
      if (n == 13) begin
        a.controle_escrita = 1'b1; a.endereco_escrita = 5'd9; a.dado_escrita = 32'hBAD0BAD0;
        a.endereco_2 = 5'd9;
        #1;
        chk("busy_no_bypass", a.dado_2, 32'd0);
      end
      if (n == 14) begin
        a.controle_escrita = 1'b0;
        #1;
        chk("busy_write_dropped", a.dado_2, 32'd0);
      end
      if (n == 21) a.limpar = 1'b1;
      if (n == 22) a.limpar = 1'b0;
      @(negedge clock);
    end
    chk("clear_busy_cycles", 32'(oc), 32'd32);
    chk("clear_done_pulses", 32'(cc), 32'd1);
    chk("clear_done_cycle", 32'(cyc), 32'd33);
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      a.endereco_1 = 5'(i); a.endereco_2 = 5'(31 - i);
      #1;
      chk($sformatf("cleared_rd1_%0d", i), a.dado_1, 32'd0);
      chk($sformatf("cleared_rd2_%0d", 31 - i), a.dado_2, 32'd0);
    end

    // Asynchronous reset in the middle of a clear.
    wr_a(5'd31, 32'h77);
    @(negedge clock); a.limpar = 1'b1;
    @(negedge clock); a.limpar = 1'b0;
    for (int n = 1; n < 10; n++) @(negedge clock);
    #1;
    chk("pre_reset_busy", {31'b0, a.ocupado}, 32'd1);
    a.endereco_1 = 5'd31;
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_ocupado", {31'b0, a.ocupado}, 32'd0);
    chk("async_reset_concluido", {31'b0, a.concluido}, 32'd0);
    chk("async_reset_rd31", a.dado_1, 32'd0);
    @(negedge clock); reset = 1'b0;
    cc = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (a.concluido) cc++;
      @(negedge clock);
    end
    chk("aborted_no_done", 32'(cc), 32'd0);
    clear_a(oc, cc, cyc);
    chk("reclear_busy_cycles", 32'(oc), 32'd32);
    chk("reclear_done_pulses", 32'(cc), 32'd1);
    chk("reclear_done_cycle", 32'(cyc), 32'd33);

    // Narrow, shallow instance with an ordinary entry 0.
    wr_c(3'd0, 16'hFFFF);
    c.endereco_1 = 3'd0;
    #1;
    chk("c_reg0_ffff", {16'b0, c.dado_1}, 32'h0000FFFF);
    @(negedge clock); c.limpar = 1'b1;
    @(negedge clock); c.limpar = 1'b0;
    oc = 0; cyc = 0;
    for (int n = 1; n <= 20; n++) begin
      #1;
      if (c.ocupado) oc++;
      if (c.concluido) begin cyc = n; break; end
      @(negedge clock);
    end
    chk("c_busy_cycles", 32'(oc), 32'd8);
    chk("c_done_cycle", 32'(cyc), 32'd9);
    // Back-to-back restart from the done cycle, with a write landing on entry 0.
    c.limpar = 1'b1; c.controle_escrita = 1'b1; c.endereco_escrita = 3'd0; c.dado_escrita = 16'hABCD;
    @(negedge clock);
    c.limpar = 1'b0; c.controle_escrita = 1'b0;
    oc = 0;
    for (int n = 1; n <= 20; n++) begin
      #1;
      if (c.ocupado) oc++;
      if (n == 1) chk("c_restart_reg0_written", {16'b0, c.dado_1}, 32'h0000ABCD);
      if (n == 2) chk("c_ptr_restart_at_0", {16'b0, c.dado_1}, 32'd0);
      @(negedge clock);
    end
    chk("c_restart_busy_cycles", 32'(oc), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
